aq_djpeg_marker_ctrl: RTL and testbench

Marker-level sequencer for the JPEG decoder front end. It drives the bit-register block's consume strobes to walk the header: SOI, table segments, SOF0, DRI and SOS. Table payload bytes go out to the DQT/DHT loaders, and image geometry is captured. After the SOS header it raises `ImageEnable` for the entropy decoder and holds it until the image completes, then pulses the block back to idle.

---
 rtl/aq_djpeg_marker_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_aq_djpeg_marker_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_marker_ctrl.sv
// JPEG header marker sequencer: walks SOI / table / SOF0 / DRI / SOS segments by
// strobing byte/word consumes, forwards DQT/DHT payload, then gates the entropy decoder.
module aq_djpeg_marker_ctrl (
    input  logic        rst,
    input  logic        clk,
    input  logic        Start,
    input  logic [31:0] DataOut,
    input  logic        DataOutEnable,
    input  logic        DataOutEnd,
    input  logic        DecodeDone,
    output logic        UseByte,
    output logic        UseWord,
    output logic        ImageEnable,
    output logic        ProcessIdle,
    output logic        TableValid,
    output logic        TableSel,
    output logic [7:0]  TableByte,
    output logic [15:0] ImageHeight,
    output logic [15:0] ImageWidth,
    output logic [15:0] RestartInterval,
    output logic        Error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SOI   = 3'd1,
        S_MARK  = 3'd2,
        S_LEN   = 3'd3,
        S_BODY  = 3'd4,
        S_IMAGE = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_mk;
    logic [15:0] r_rem;
    logic [15:0] r_off;
    logic [15:0] r_height;
    logic [15:0] r_width;
    logic [15:0] r_restart;
    logic        r_tvalid;
    logic        r_tsel;
    logic [7:0]  r_tbyte;

    logic [7:0]  w_byte0;
    logic [7:0]  w_byte1;
    logic [15:0] w_len;
    logic        w_mark_bad;
    logic        w_mk_unsup;
    logic        w_mk_table;
    logic        w_last;
    logic        w_restart_ok;
    logic        w_unused;

    assign w_byte0  = DataOut[31:24];
    assign w_byte1  = DataOut[23:16];
    assign w_len    = DataOut[31:16];
    assign w_unused = ^DataOut[15:0];

    // SOI, EOI and RSTn may not appear between header segments.
    assign w_mark_bad = (w_byte1 == 8'hD8) || (w_byte1 == 8'hD9) || (w_byte1[7:3] == 5'b11010);
    // Non-baseline SOFn: C4 is DHT, C8 is reserved JPG, CC is DAC.
    assign w_mk_unsup = (r_mk[7:4] == 4'hC) && (r_mk[3:0] != 4'h0) &&
                        (r_mk != 8'hC4) && (r_mk != 8'hC8) && (r_mk != 8'hCC);
    assign w_mk_table = (r_mk == 8'hDB) || (r_mk == 8'hC4);
    assign w_last     = (r_rem == 16'd1);
    assign w_restart_ok = ((r_state == S_IDLE) || (r_state == S_ERR)) && Start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_SOI;
            S_SOI:   if (DataOutEnable) w_next = (w_len == 16'hFFD8) ? S_MARK : S_ERR;
            S_MARK: begin
                if (DataOutEnable) begin
                    if (w_byte0 != 8'hFF)      w_next = S_ERR;
                    else if (w_byte1 == 8'hFF) w_next = S_MARK;
                    else if (w_mark_bad)       w_next = S_ERR;
                    else                       w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (DataOutEnable) begin
                    if (w_len < 16'd2)       w_next = S_ERR;
                    else if (w_len == 16'd2) w_next = (r_mk == 8'hDA) ? S_ERR : S_MARK;
                    else                     w_next = S_BODY;
                end
            end
            S_BODY: begin
                if (DataOutEnable) begin
                    if (w_mk_unsup) begin
                        w_next = S_ERR;
                    end else if (w_last) begin
                        if (r_mk != 8'hDA)          w_next = S_MARK;
                        else if (r_width == 16'd0)  w_next = S_ERR;
                        else                        w_next = S_IMAGE;
                    end
                end
            end
            S_IMAGE: if (DataOutEnd && DecodeDone) w_next = S_IDLE;
            S_ERR:   if (Start) w_next = S_SOI;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        UseByte     = 1'b0;
        UseWord     = 1'b0;
        ImageEnable = (r_state == S_IMAGE);
        ProcessIdle = (r_state == S_IDLE) || (r_state == S_ERR);
        Error       = (r_state == S_ERR);
        if (DataOutEnable) begin
            case (r_state)
                S_SOI:  UseWord = (w_len == 16'hFFD8);
                S_MARK: begin
                    if (w_byte0 == 8'hFF) begin
                        if (w_byte1 == 8'hFF) UseByte = 1'b1;
                        else if (!w_mark_bad) UseWord = 1'b1;
                    end
                end
                S_LEN:  UseWord = (w_len >= 16'd2);
                S_BODY: UseByte = !w_mk_unsup;
                default: begin
                    UseByte = 1'b0;
                    UseWord = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mk      <= 8'd0;
            r_rem     <= 16'd0;
            r_off     <= 16'd0;
            r_height  <= 16'd0;
            r_width   <= 16'd0;
            r_restart <= 16'd0;
            r_tvalid  <= 1'b0;
            r_tsel    <= 1'b0;
            r_tbyte   <= 8'd0;
        end else begin
            r_tvalid <= 1'b0;
            if (w_restart_ok) begin
                r_height  <= 16'd0;
                r_width   <= 16'd0;
                r_restart <= 16'd0;
            end
            if ((r_state == S_MARK) && UseWord) begin
                r_mk <= w_byte1;
            end
            if ((r_state == S_LEN) && UseWord) begin
                r_rem <= w_len - 16'd2;
                r_off <= 16'd0;
            end
            if ((r_state == S_BODY) && UseByte) begin
                r_rem <= r_rem - 16'd1;
                r_off <= r_off + 16'd1;
                if (w_mk_table) begin
                    r_tvalid <= 1'b1;
                    r_tbyte  <= w_byte0;
                    r_tsel   <= (r_mk == 8'hC4);
                end
                // SOF0 payload: P, Y(2), X(2), ...
                if (r_mk == 8'hC0) begin
                    case (r_off)
                        16'd1:   r_height[15:8] <= w_byte0;
                        16'd2:   r_height[7:0]  <= w_byte0;
                        16'd3:   r_width[15:8]  <= w_byte0;
                        16'd4:   r_width[7:0]   <= w_byte0;
                        default: r_height       <= r_height;
                    endcase
                end
                if (r_mk == 8'hDD) begin
                    case (r_off)
                        16'd0:   r_restart[15:8] <= w_byte0;
                        16'd1:   r_restart[7:0]  <= w_byte0;
                        default: r_restart       <= r_restart;
                    endcase
                end
            end
        end
    end

    assign TableValid      = r_tvalid;
    assign TableSel        = r_tsel;
    assign TableByte       = r_tbyte;
    assign ImageHeight     = r_height;
    assign ImageWidth      = r_width;
    assign RestartInterval = r_restart;

endmodule

// File: tb/tb_aq_djpeg_marker_ctrl.sv
// Bench for aq_djpeg_marker_ctrl: emulates the bit register over a byte stream and
// compares against fixed vectors and a byte-level header parser model.
module tb_aq_djpeg_marker_ctrl;

    logic        rst, clk, Start, DataOutEnable, DataOutEnd, DecodeDone;
    logic [31:0] DataOut;
    logic        UseByte, UseWord, ImageEnable, ProcessIdle, TableValid, TableSel, Error;
    logic [7:0]  TableByte;
    logic [15:0] ImageHeight, ImageWidth, RestartInterval;

    aq_djpeg_marker_ctrl dut (
        .rst(rst), .clk(clk), .Start(Start), .DataOut(DataOut),
        .DataOutEnable(DataOutEnable), .DataOutEnd(DataOutEnd), .DecodeDone(DecodeDone),
        .UseByte(UseByte), .UseWord(UseWord), .ImageEnable(ImageEnable),
        .ProcessIdle(ProcessIdle), .TableValid(TableValid), .TableSel(TableSel),
        .TableByte(TableByte), .ImageHeight(ImageHeight), .ImageWidth(ImageWidth),
        .RestartInterval(RestartInterval), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] s[$];
    logic [8:0] tq_obs[$];
    logic [8:0] tq_exp[$];
    int pos;
    bit cool;

    typedef struct {
        bit err, img, start_use, rise_ok, idle_ok, hold_ok, timeout, aborted;
        logic [15:0] h, w, ri;
        int ub, uw, viol;
    } obs_t;

    typedef struct {
        bit err, img;
        int cons;
        logic [15:0] h, w, ri;
    } exp_t;

    typedef struct {
        int kind;
        bit e_err, e_img;
        logic [15:0] e_h, e_w, e_ri;
        int e_ub, e_uw, e_n0, e_n1;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gb(input int p);
        return (p < s.size()) ? s[p] : 8'h00;
    endfunction

    task automatic seg(input logic [7:0] mk, input int n);
        s.push_back(8'hFF); s.push_back(mk);
        s.push_back(8'((n + 2) >> 8)); s.push_back(8'((n + 2) & 255));
        for (int i = 0; i < n; i++) s.push_back(8'($urandom));
    endtask

    task automatic sof0(input logic [15:0] h, input logic [15:0] w);
        s.push_back(8'hFF); s.push_back(8'hC0); s.push_back(8'h00); s.push_back(8'h0B);
        s.push_back(8'h08); s.push_back(h[15:8]); s.push_back(h[7:0]);
        s.push_back(w[15:8]); s.push_back(w[7:0]);
        s.push_back(8'h01); s.push_back(8'h01); s.push_back(8'h11); s.push_back(8'h00);
    endtask

    task automatic soi();
        s.push_back(8'hFF); s.push_back(8'hD8);
    endtask

    task automatic build(input int kind);
        s.delete();
        case (kind)
            0: begin soi(); sof0(16'h0010, 16'h0020); seg(8'hDA, 6); end
            1: begin soi(); s.push_back(8'hFF); seg(8'hE0, 14); sof0(16'h0010, 16'h0020); seg(8'hDA, 6); end
            2: begin soi(); seg(8'hDB, 65); seg(8'hC4, 29); sof0(16'h0010, 16'h0020); seg(8'hDA, 6); end
            3: begin
                soi();
                s.push_back(8'hFF); s.push_back(8'hDD); s.push_back(8'h00);
                s.push_back(8'h04); s.push_back(8'h00); s.push_back(8'h20);
                sof0(16'h0010, 16'h0020); seg(8'hDA, 6);
            end
            4: begin s.push_back(8'hFF); s.push_back(8'hD9); s.push_back(8'h00); s.push_back(8'h00); end
            5: begin soi(); s.push_back(8'hFF); s.push_back(8'hE0); s.push_back(8'h00); s.push_back(8'h01); end
            6: begin soi(); seg(8'hDA, 6); end
            7: begin soi(); seg(8'hC2, 15); end
            default: begin soi(); s.push_back(8'hFF); s.push_back(8'hD9); end
        endcase
    endtask

    task automatic gen_random();
        logic [7:0] unsup[12];
        unsup = '{8'hC1, 8'hC2, 8'hC3, 8'hC5, 8'hC6, 8'hC7, 8'hC9, 8'hCA, 8'hCB, 8'hCD, 8'hCE, 8'hCF};
        s.delete();
        if ($urandom_range(0, 19) == 0) begin s.push_back(8'hFF); s.push_back(8'hD9); end
        else soi();
        for (int i = 0; i < int'($urandom_range(0, 4)); i++) begin
            case ($urandom_range(0, 9))
                0: s.push_back(8'hFF);
                1, 2: seg(8'hE0 + 8'($urandom_range(0, 15)), $urandom_range(0, 10));
                3: seg(8'hDB, $urandom_range(1, 12));
                4: seg(8'hC4, $urandom_range(1, 12));
                5: seg(8'hDD, 2);
                6: sof0(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)));
                7: seg(8'hFE, $urandom_range(1, 8));
                8: begin
                    case ($urandom_range(0, 3))
                        0: begin s.push_back(8'hFF); s.push_back(8'hD0 + 8'($urandom_range(0, 9))); end
                        1: begin s.push_back(8'hFF); s.push_back(8'hE1); s.push_back(8'h00); s.push_back(8'h01); end
                        2: seg(unsup[$urandom_range(0, 11)], 3);
                        default: s.push_back(8'h12);
                    endcase
                end
                default: seg(8'hE2, 0);
            endcase
        end
        if ($urandom_range(0, 3) != 0)
            sof0(16'($urandom_range(1, 65535)), ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 65535)));
        seg(8'hDA, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8));
    endtask

    // Byte-level walk of the header following the marker/length/payload rules.
    task automatic ref_parse(output exp_t e);
        int p, L, n;
        logic [7:0] mk, b;
        e.err = 0; e.img = 0; e.cons = 0; e.h = 0; e.w = 0; e.ri = 0;
        tq_exp.delete();
        if ({gb(0), gb(1)} != 16'hFFD8) begin e.err = 1; return; end
        p = 2;
        while (p < 100000) begin
            if (gb(p) != 8'hFF) begin e.err = 1; break; end
            if (gb(p + 1) == 8'hFF) begin p++; continue; end
            mk = gb(p + 1);
            if (mk == 8'hD8 || mk == 8'hD9 || (mk >= 8'hD0 && mk <= 8'hD7)) begin e.err = 1; break; end
            p += 2;
            L = int'({gb(p), gb(p + 1)});
            if (L < 2) begin e.err = 1; break; end
            p += 2;
            n = L - 2;
            if (n == 0) begin
                if (mk == 8'hDA) begin e.err = 1; break; end
                continue;
            end
            if (mk >= 8'hC1 && mk <= 8'hCF && mk != 8'hC4 && mk != 8'hC8 && mk != 8'hCC) begin
                e.err = 1; break;
            end
            for (int i = 0; i < n; i++) begin
                b = gb(p + i);
                if (mk == 8'hDB || mk == 8'hC4) tq_exp.push_back({mk == 8'hC4, b});
                if (mk == 8'hC0) begin
                    if (i == 1) e.h[15:8] = b;
                    if (i == 2) e.h[7:0] = b;
                    if (i == 3) e.w[15:8] = b;
                    if (i == 4) e.w[7:0] = b;
                end
                if (mk == 8'hDD) begin
                    if (i == 0) e.ri[15:8] = b;
                    if (i == 1) e.ri[7:0] = b;
                end
            end
            p += n;
            if (mk == 8'hDA) begin
                if (e.w == 16'd0) e.err = 1; else e.img = 1;
                break;
            end
        end
        e.cons = p;
    endtask

    task automatic drive_bits(input bit stall);
        if (cool) begin
            DataOutEnable = 1'b0;
            cool = 1'b0;
        end else begin
            DataOutEnable = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        DataOut = {gb(pos), gb(pos + 1), gb(pos + 2), gb(pos + 3)};
    endtask

    task automatic run_stream(input bit rnd, input int abort_tv, output obs_t o);
        int last_use;
        bit done, seen_img;
        o.err = 0; o.img = 0; o.start_use = 0; o.rise_ok = 0; o.idle_ok = 0; o.hold_ok = 0;
        o.timeout = 0; o.aborted = 0; o.h = 0; o.w = 0; o.ri = 0; o.ub = 0; o.uw = 0; o.viol = 0;
        pos = 0; cool = 0; tq_obs.delete(); last_use = -10; done = 0; seen_img = 0;
        @(posedge clk); #1;
        Start = 1'b1; DecodeDone = 1'b0; DataOutEnd = 1'b0; DataOutEnable = 1'b1;
        DataOut = {gb(0), gb(1), gb(2), gb(3)};
        #1;
        o.start_use = UseByte || UseWord;
        @(posedge clk); #1;
        Start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive_bits(rnd);
            Start = rnd && !ProcessIdle && ($urandom_range(0, 15) == 0);
            #1;
            if (TableValid) tq_obs.push_back({TableSel, TableByte});
            if (ImageEnable) begin
                seen_img = 1; done = 1; o.rise_ok = (last_use == cyc - 1);
                break;
            end
            if (ProcessIdle && Error) begin done = 1; break; end
            if (UseByte || UseWord) begin
                if (!DataOutEnable || (UseByte && UseWord)) o.viol++;
                if (UseByte) begin o.ub++; pos += 1; end
                else begin o.uw++; pos += 2; end
                cool = 1; last_use = cyc;
            end
            if (abort_tv > 0 && tq_obs.size() >= abort_tv) begin
                Start = 1'b0; o.aborted = 1;
                return;
            end
            @(posedge clk); #1;
        end
        Start = 1'b0;
        o.err = Error; o.h = ImageHeight; o.w = ImageWidth; o.ri = RestartInterval;
        if (!done) o.timeout = 1;
        if (seen_img) begin
            o.img = 1; o.hold_ok = 1;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                DataOutEnable = 1'b1; DataOut = $urandom;
                DataOutEnd = (i == 1); DecodeDone = (i == 3);
                #1;
                if (UseByte || UseWord) o.viol++;
                if (!ImageEnable || ProcessIdle) o.hold_ok = 0;
            end
            @(posedge clk); #1;
            DataOutEnd = 1'b1; DecodeDone = 1'b1;
            #1;
            if (!ImageEnable || UseByte || UseWord) o.hold_ok = 0;
            @(posedge clk); #1;
            DataOutEnd = 1'b0; DecodeDone = 1'b0; DataOutEnable = 1'b0;
            #1;
            o.idle_ok = ProcessIdle && !ImageEnable;
        end
    endtask

    task automatic chk_tables(input string nm);
        int bad;
        bad = -1;
        checks++;
        if (tq_obs.size() != tq_exp.size()) bad = 99999;
        else for (int i = 0; i < tq_obs.size(); i++) if (bad < 0 && tq_obs[i] !== tq_exp[i]) bad = i;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: table stream differs at %0d (got %0d entries, expected %0d)",
                     nm, bad, tq_obs.size(), tq_exp.size());
        end
    endtask

    task automatic chk_common(input string nm, input obs_t o, input exp_t e);
        chk({nm, "_err"}, o.err, e.err);
        chk({nm, "_img"}, o.img, e.img);
        chk({nm, "_consumed"}, pos, e.cons);
        chk({nm, "_h"}, o.h, e.h);
        chk({nm, "_w"}, o.w, e.w);
        chk({nm, "_ri"}, o.ri, e.ri);
        chk({nm, "_viol"}, o.viol, 0);
        chk({nm, "_start_use"}, o.start_use, 0);
        chk({nm, "_timeout"}, o.timeout, 0);
        chk_tables({nm, "_tables"});
        if (e.img) begin
            chk({nm, "_rise"}, o.rise_ok, 1);
            chk({nm, "_hold"}, o.hold_ok, 1);
            chk({nm, "_idle"}, o.idle_ok, 1);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_idle"}, ProcessIdle, 1);
        chk({nm, "_ub"}, UseByte, 0);
        chk({nm, "_uw"}, UseWord, 0);
        chk({nm, "_ie"}, ImageEnable, 0);
        chk({nm, "_tv"}, TableValid, 0);
        chk({nm, "_ts"}, TableSel, 0);
        chk({nm, "_tb"}, TableByte, 0);
        chk({nm, "_h"}, ImageHeight, 0);
        chk({nm, "_w"}, ImageWidth, 0);
        chk({nm, "_ri"}, RestartInterval, 0);
        chk({nm, "_err"}, Error, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        exp_t e;
        int n0, n1;
        string nm;

        vt[0] = '{0, 0, 1, 16'h0010, 16'h0020, 16'h0000, 15, 5, 0, 0};
        vt[1] = '{1, 0, 1, 16'h0010, 16'h0020, 16'h0000, 30, 7, 0, 0};
        vt[2] = '{2, 0, 1, 16'h0010, 16'h0020, 16'h0000, 109, 9, 65, 29};
        vt[3] = '{3, 0, 1, 16'h0010, 16'h0020, 16'h0020, 17, 7, 0, 0};
        vt[4] = '{4, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
        vt[5] = '{5, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 2, 0, 0};
        vt[6] = '{6, 1, 0, 16'h0000, 16'h0000, 16'h0000, 6, 3, 0, 0};
        vt[7] = '{7, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 3, 0, 0};
        vt[8] = '{8, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0};

        rst = 1'b0; Start = 1'b0; DataOut = 32'hFFD8FFC0; DataOutEnable = 1'b1;
        DataOutEnd = 1'b0; DecodeDone = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 9; k++) begin
            build(vt[k].kind);
            ref_parse(e);
            run_stream(1'b0, 0, o);
            nm = $sformatf("vec%0d", k);
            n0 = 0; n1 = 0;
            foreach (tq_obs[i]) if (tq_obs[i][8]) n1++; else n0++;
            chk({nm, "_err_c"}, o.err, vt[k].e_err);
            chk({nm, "_pidle"}, ProcessIdle, 1);
            chk({nm, "_img_c"}, o.img, vt[k].e_img);
            chk({nm, "_h_c"}, o.h, vt[k].e_h);
            chk({nm, "_w_c"}, o.w, vt[k].e_w);
            chk({nm, "_ri_c"}, o.ri, vt[k].e_ri);
            chk({nm, "_nub"}, o.ub, vt[k].e_ub);
            chk({nm, "_nuw"}, o.uw, vt[k].e_uw);
            chk({nm, "_ndqt"}, n0, vt[k].e_n0);
            chk({nm, "_ndht"}, n1, vt[k].e_n1);
            chk_common(nm, o, e);
        end

        // Reset asserted mid-DQT body, away from a clock edge.
        build(2);
        run_stream(1'b0, 10, o);
        chk("mid_rst_reached_dqt", o.aborted, 1);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("mid_rst_no_tv", TableValid, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        build(0);
        ref_parse(e);
        run_stream(1'b0, 0, o);
        chk_common("after_rst", o, e);
        chk("after_rst_h", o.h, 16'h0010);
        chk("after_rst_w", o.w, 16'h0020);

        for (int r = 0; r < 30; r++) begin
            gen_random();
            ref_parse(e);
            run_stream(1'b1, 0, o);
            chk_common($sformatf("rnd%0d", r), o, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
